// File: rtl/esm_dep_scheduler_pkg.sv
// Shared types, sizes and field helpers for the ESM dependency scheduler.
package esm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REGNUM  = 32;
  localparam int unsigned RA_W    = $clog2(REGNUM);
  localparam int unsigned BS      = 16;
  localparam int unsigned IX_W    = $clog2(BS);
  localparam int unsigned OCC_W   = IX_W + 1;

  // Fixed register field positions in the instruction word
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RD_LSB  = 7;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_WAIT   = 2'd1,
    SLOT_ISSUED = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } reg_fields_t;

  // Unused rs2 / unwritten rd collapse to x0 so they never match anything
  function automatic reg_fields_t extract_fields(input logic [INSTR_W-1:0] instr,
                                                 input logic               use_rs2,
                                                 input logic               reg_write);
    reg_fields_t f;
    f.rs1 = instr[RS1_LSB +: RA_W];
    f.rs2 = use_rs2   ? instr[RS2_LSB +: RA_W] : '0;
    f.rd  = reg_write ? instr[RD_LSB  +: RA_W] : '0;
    return f;
  endfunction

endpackage

// File: rtl/esm_dep_scheduler_if.sv
// Alloc / issue / complete handshake bundle of esm_dep_scheduler.
interface esm_dep_scheduler_if;
  import esm_pkg::*;

  logic               alloc_valid;
  logic               alloc_ready;
  logic [INSTR_W-1:0] instr_in;
  logic               use_rs2;
  logic               reg_write;
  logic [IX_W-1:0]    alloc_index;
  logic               issue_valid;
  logic               issue_ready;
  logic [IX_W-1:0]    issue_index;
  logic [INSTR_W-1:0] issue_instr;
  logic               complete_valid;
  logic [IX_W-1:0]    complete_index;
  logic [OCC_W-1:0]   occupancy;
  logic               full;
  logic               empty;

  modport slave (
    input  alloc_valid, instr_in, use_rs2, reg_write, issue_ready,
           complete_valid, complete_index,
    output alloc_ready, alloc_index, issue_valid, issue_index, issue_instr,
           occupancy, full, empty
  );

  modport master (
    output alloc_valid, instr_in, use_rs2, reg_write, issue_ready,
           complete_valid, complete_index,
    input  alloc_ready, alloc_index, issue_valid, issue_index, issue_instr,
           occupancy, full, empty
  );

endinterface

// File: rtl/esm_dep_scheduler_dep_row.sv
// Combinational IDT row for a newly allocated instruction against all live slots.
// ESM_WAR_WAW_CHECK_EN adds WAR/WAW terms; otherwise RAW only.
module esm_dep_row
  import esm_pkg::*;
(
  input  reg_fields_t            new_fields,
  input  logic [BS-1:0]          slot_live,
  input  reg_fields_t [BS-1:0]   slot_fields,
  output logic [BS-1:0]          dep_row_c
);

  always_comb begin
    dep_row_c = '0;
    for (int j = 0; j < int'(BS); j++) begin
      // RAW: older slot writes a register this one reads
      if (slot_live[j] && (slot_fields[j].rd != '0) &&
          ((slot_fields[j].rd == new_fields.rs1) || (slot_fields[j].rd == new_fields.rs2)))
        dep_row_c[j] = 1'b1;
`ifdef ESM_WAR_WAW_CHECK_EN
      // WAR / WAW: this slot overwrites a register the older slot reads or writes
      if (slot_live[j] && (new_fields.rd != '0) &&
          ((new_fields.rd == slot_fields[j].rs1) || (new_fields.rd == slot_fields[j].rs2) ||
           (new_fields.rd == slot_fields[j].rd)))
        dep_row_c[j] = 1'b1;
`endif
    end
  end

`ifndef ESM_WAR_WAW_CHECK_EN
  logic unused_order_fields;
  assign unused_order_fields = ^{new_fields.rd, slot_fields};
`endif

endmodule

// File: rtl/esm_dep_scheduler.sv
// Registered dependency scheduler: slot buffer, IDT and age matrix with oldest-ready issue.
// Build option ESM_WAR_WAW_CHECK_EN (in esm_dep_row) enables WAR/WAW tracking.
module esm_dep_scheduler
  import esm_pkg::*;
(
  input logic                clk,
  input logic                reset,
  esm_dep_scheduler_if.slave bus
);

  slot_state_e          state_q [BS];
  slot_state_e          state_d [BS];
  logic [BS-1:0]        idt_q   [BS];
  logic [BS-1:0]        idt_d   [BS];
  logic [BS-1:0]        older_q [BS];
  logic [BS-1:0]        older_d [BS];
  logic [INSTR_W-1:0]   instr_q [BS];
  reg_fields_t [BS-1:0] fields_q;
  logic [OCC_W-1:0]     occ_q, occ_d;

  logic [BS-1:0]   free_vec, ready_vec, complete_vec, live_vec, dep_row;
  logic [IX_W-1:0] alloc_idx, issue_idx;
  logic            alloc_fire, issue_fire, complete_fire;
  reg_fields_t     new_fields;

  // Per-slot status vectors
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < int'(BS); i++) begin
      free_vec[i]  = (state_q[i] == SLOT_FREE);
      ready_vec[i] = (state_q[i] == SLOT_WAIT) && (idt_q[i] == '0);
    end
  end

  // Lowest-index free slot
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(BS) - 1; i >= 0; i--)
      if (free_vec[i]) alloc_idx = IX_W'(i);
  end

  // Oldest ready slot: ready with no older ready slot
  always_comb begin
    issue_idx = '0;
    for (int i = int'(BS) - 1; i >= 0; i--)
      if (ready_vec[i] && ((older_q[i] & ready_vec) == '0)) issue_idx = IX_W'(i);
  end

  assign alloc_fire    = bus.alloc_valid && bus.alloc_ready;
  assign issue_fire    = bus.issue_valid && bus.issue_ready;
  assign complete_fire = bus.complete_valid && (state_q[bus.complete_index] == SLOT_ISSUED);
  assign complete_vec  = complete_fire ? (BS'(1) << bus.complete_index) : '0;
  assign live_vec      = ~free_vec & ~complete_vec;
  assign new_fields    = extract_fields(bus.instr_in, bus.use_rs2, bus.reg_write);

  esm_dep_row u_dep_row (
    .new_fields  (new_fields),
    .slot_live   (live_vec),
    .slot_fields (fields_q),
    .dep_row_c   (dep_row)
  );

  assign bus.alloc_ready = |free_vec;
  assign bus.alloc_index = alloc_idx;
  assign bus.issue_valid = |ready_vec;
  assign bus.issue_index = issue_idx;
  assign bus.issue_instr = instr_q[issue_idx];
  assign bus.occupancy   = occ_q;
  assign bus.full        = (occ_q == OCC_W'(BS));
  assign bus.empty       = (occ_q == '0);

  // Next state for slot states, IDT and age matrix
  always_comb begin
    state_d = state_q;
    idt_d   = idt_q;
    older_d = older_q;
    occ_d   = occ_q + OCC_W'(alloc_fire) - OCC_W'(complete_fire);
    for (int k = 0; k < int'(BS); k++) begin
      if (complete_fire) idt_d[k][bus.complete_index] = 1'b0;
      if (alloc_fire)    older_d[k][alloc_idx]        = 1'b0;
    end
    if (issue_fire)    state_d[issue_idx]          = SLOT_ISSUED;
    if (complete_fire) state_d[bus.complete_index] = SLOT_FREE;
    if (alloc_fire) begin
      state_d[alloc_idx] = SLOT_WAIT;
      idt_d[alloc_idx]   = dep_row;
      older_d[alloc_idx] = live_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BS); i++) begin
        state_q[i] <= SLOT_FREE;
        idt_q[i]   <= '0;
        older_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < int'(BS); i++) begin
        state_q[i] <= state_d[i];
        idt_q[i]   <= idt_d[i];
        older_q[i] <= older_d[i];
      end
      occ_q <= occ_d;
    end
  end

  // Payload is only meaningful while the slot is non-FREE, so it needs no reset
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      instr_q[alloc_idx]  <= bus.instr_in;
      fields_q[alloc_idx] <= new_fields;
    end
  end

endmodule

// File: tb/tb_esm_dep_scheduler.sv
// Directed scoreboard bench for esm_dep_scheduler: expected allocs/issues are queued
// by the stimulus and popped by a negedge monitor when the DUT handshakes fire.
module tb_esm_dep_scheduler;
  import esm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  esm_dep_scheduler_if bus ();

  esm_dep_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ESM_WAR_WAW_CHECK_EN
  localparam bit ORDER_CHECK = 1'b1;
`else
  localparam bit ORDER_CHECK = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int          exp_alloc_q[$];
  int          exp_issue_slot_q[$];
  logic [31:0] exp_issue_instr_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
  endfunction

  // Monitor: compare every accepted alloc/issue against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.alloc_valid && bus.alloc_ready) begin
        if (exp_alloc_q.size() == 0) chk("unexpected_alloc", int'(bus.alloc_index), -1);
        else                         chk("alloc_index", int'(bus.alloc_index), exp_alloc_q.pop_front());
      end
      if (bus.issue_valid && bus.issue_ready) begin
        if (exp_issue_slot_q.size() == 0) chk("unexpected_issue", int'(bus.issue_index), -1);
        else begin
          chk("issue_index", int'(bus.issue_index), exp_issue_slot_q.pop_front());
          chk("issue_instr", int'(bus.issue_instr), int'(exp_issue_instr_q.pop_front()));
        end
      end
    end
  end

  // One cycle of stimulus; ea<0 means alloc must not fire, is_slot/c_idx<0 means idle
  task automatic tick(input bit a, input logic [31:0] ins, input bit u2, input bit rw, input int ea,
                      input int is_slot, input logic [31:0] is_ins, input int c_idx);
    bus.alloc_valid = a;
    bus.instr_in    = ins;
    bus.use_rs2     = u2;
    bus.reg_write   = rw;
    if (a && ea >= 0) exp_alloc_q.push_back(ea);
    if (is_slot >= 0) begin
      chk("issue_avail", int'(bus.issue_valid), 1);
      if (bus.issue_valid) begin
        exp_issue_slot_q.push_back(is_slot);
        exp_issue_instr_q.push_back(is_ins);
        bus.issue_ready = 1'b1;
      end
    end
    bus.complete_valid = (c_idx >= 0);
    bus.complete_index = IX_W'((c_idx >= 0) ? c_idx : 0);
    @(posedge clk);
    #1;
    bus.alloc_valid    = 1'b0;
    bus.issue_ready    = 1'b0;
    bus.complete_valid = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] ins, input bit u2, input bit rw, input int slot);
    tick(1'b1, ins, u2, rw, slot, -1, '0, -1);
  endtask

  task automatic issue(input int slot, input logic [31:0] ins);
    tick(1'b0, '0, 1'b1, 1'b1, -1, slot, ins, -1);
  endtask

  task automatic complete(input int idx);
    tick(1'b0, '0, 1'b1, 1'b1, -1, -1, '0, idx);
  endtask

  task automatic chk_occ(input int n);
    chk("occupancy",   int'(bus.occupancy),   n);
    chk("empty",       int'(bus.empty),       (n == 0)  ? 1 : 0);
    chk("full",        int'(bus.full),        (n == 16) ? 1 : 0);
    chk("alloc_ready", int'(bus.alloc_ready), (n < 16)  ? 1 : 0);
  endtask

  task automatic chk_issue(input int v, input int idx);
    chk("issue_valid", int'(bus.issue_valid), v);
    if (v != 0) chk("issue_pick", int'(bus.issue_index), idx);
  endtask

  initial begin
    reset              = 1'b1;
    bus.alloc_valid    = 1'b0;
    bus.instr_in       = '0;
    bus.use_rs2        = 1'b1;
    bus.reg_write      = 1'b1;
    bus.issue_ready    = 1'b0;
    bus.complete_valid = 1'b0;
    bus.complete_index = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk_occ(0);
    chk_issue(0, 0);
    chk("alloc_index_rst", int'(bus.alloc_index), 0);

    // RAW chain, plus alloc alongside the producer's completion
    alloc(mk(3, 1, 2), 1'b1, 1'b1, 0);
    chk_issue(1, 0);
    alloc(mk(5, 3, 4), 1'b1, 1'b1, 1);
    chk_issue(1, 0);
    chk_occ(2);
    issue(0, mk(3, 1, 2));
    chk_issue(0, 0);
    tick(1'b1, mk(8, 3, 0), 1'b1, 1'b1, 2, -1, '0, 0);
    chk_issue(1, 1);
    chk_occ(2);
    issue(1, mk(5, 3, 4));
    issue(2, mk(8, 3, 0));
    complete(1);
    complete(2);
    chk_occ(0);

    // x0 destination creates no dependents
    alloc(mk(0, 1, 2), 1'b1, 1'b1, 0);
    alloc(mk(6, 0, 0), 1'b1, 1'b1, 1);
    issue(0, mk(0, 1, 2));
    chk_issue(1, 1);
    issue(1, mk(6, 0, 0));
    complete(0);
    complete(1);

    // use_rs2=0 hides rs2=x3 from the x3 writer
    alloc(mk(3, 1, 2), 1'b1, 1'b1, 0);
    alloc(mk(7, 1, 3), 1'b0, 1'b1, 1);
    issue(0, mk(3, 1, 2));
    chk_issue(1, 1);
    issue(1, mk(7, 1, 3));
    complete(0);
    complete(1);

    // reg_write=0 hides rd=x4 from the x4 reader
    alloc(mk(4, 1, 2), 1'b1, 1'b0, 0);
    alloc(mk(9, 4, 0), 1'b1, 1'b1, 1);
    issue(0, mk(4, 1, 2));
    chk_issue(1, 1);
    issue(1, mk(9, 4, 0));
    complete(0);
    complete(1);
    chk_occ(0);

    // WAR: x2 rewritten after being read
    alloc(mk(1, 2, 3), 1'b1, 1'b1, 0);
    alloc(mk(2, 4, 5), 1'b1, 1'b1, 1);
    issue(0, mk(1, 2, 3));
    chk("war_waw_block", int'(bus.issue_valid), ORDER_CHECK ? 0 : 1);
    complete(0);
    chk_issue(1, 1);
    issue(1, mk(2, 4, 5));
    complete(1);

    // Fill, blocked alloc, completion alongside alloc_valid while full
    for (int k = 0; k < 16; k++) alloc(mk(16 + k, 0, 0), 1'b1, 1'b1, k);
    chk_occ(16);
    tick(1'b1, mk(30, 0, 0), 1'b1, 1'b1, -1, -1, '0, -1);
    chk_occ(16);
    for (int k = 0; k < 6; k++) issue(k, mk(16 + k, 0, 0));
    tick(1'b1, mk(1, 21, 0), 1'b1, 1'b1, -1, -1, '0, 5);
    chk_occ(15);
    chk("alloc_index_reuse", int'(bus.alloc_index), 5);
    alloc(mk(1, 21, 0), 1'b1, 1'b1, 5);
    chk_occ(16);
    for (int k = 6; k < 16; k++) issue(k, mk(16 + k, 0, 0));
    issue(5, mk(1, 21, 0));
    for (int k = 0; k < 16; k++) complete(k);
    chk_occ(0);

    // Age ordering: slot 7 allocated before reused slot 2, both wait on slot 0
    alloc(mk(10, 0, 0), 1'b1, 1'b1, 0);
    for (int k = 1; k < 7; k++) alloc(mk(19 + k, 0, 0), 1'b1, 1'b1, k);
    alloc(mk(12, 10, 0), 1'b1, 1'b1, 7);
    issue(0, mk(10, 0, 0));
    issue(1, mk(20, 0, 0));
    issue(2, mk(21, 0, 0));
    complete(2);
    alloc(mk(13, 10, 0), 1'b1, 1'b1, 2);
    complete(7);
    chk_occ(8);
    chk_issue(1, 3);
    for (int k = 3; k < 7; k++) issue(k, mk(19 + k, 0, 0));
    chk_issue(0, 0);
    complete(0);
    chk_issue(1, 7);
    issue(7, mk(12, 10, 0));
    issue(2, mk(13, 10, 0));
    for (int k = 1; k < 8; k++) complete(k);
    chk_occ(0);

    // Reset in the middle of operation
    alloc(mk(3, 1, 2), 1'b1, 1'b1, 0);
    alloc(mk(4, 3, 0), 1'b1, 1'b1, 1);
    chk_occ(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_occ(0);
    chk_issue(0, 0);
    chk("alloc_index_after_reset", int'(bus.alloc_index), 0);

    chk("alloc_queue_drained", exp_alloc_q.size(), 0);
    chk("issue_queue_drained", exp_issue_slot_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
